// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM states, data width and response codes.
// The AHB-to-APB bridge imports the same package.
// Optional build macro used across this slice: APB_PSTRB_EN (byte-lane write strobes).
package apb_pkg;

    localparam int APB_DATA_W = 32;

    // slvErr encodings
    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Width of the register index field; never below 1 so one-register banks still decode.
    function automatic int apb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_reg_completer_if.sv
// APB completer-side bus bundle. Build macro APB_PSTRB_EN adds the strb lanes.
//
// Handshake: the requester raises sel with enable=0 for one setup cycle, then
// raises enable and holds addr/write/wData (and strb) stable. The transfer
// completes on the rising edge where sel & enable & ready are all 1; rData and
// slvErr are meaningful only in that cycle and read as 0 otherwise.
interface apb_reg_completer_if;
    import apb_pkg::*;

    logic                  sel;
    logic                  enable;
    logic                  write;
    logic [APB_DATA_W-1:0] addr;
    logic [APB_DATA_W-1:0] wData;
    logic [APB_DATA_W-1:0] rData;
    logic                  ready;
    logic                  slvErr;
`ifdef APB_PSTRB_EN
    logic [3:0]            strb;
`endif

    modport master (
`ifdef APB_PSTRB_EN
        output strb,
`endif
        output sel, enable, addr, write, wData,
        input  rData, ready, slvErr
    );

    modport slave (
`ifdef APB_PSTRB_EN
        input  strb,
`endif
        input  sel, enable, addr, write, wData,
        output rData, ready, slvErr
    );

endinterface

// File: rtl/apb_reg_bank.sv
// Register storage for the APB completer: address/error decode, read mux with
// hardware status slots for read-only registers, and byte-lane write merge.
// The strb input is always present here; the top ties it to all-ones unless
// APB_PSTRB_EN is defined.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int                 NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0,
    parameter int                 FLD_W    = apb_idx_w(NUM_REGS) + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    // setup-phase decode
    input  logic [FLD_W+1:0]               dec_addr,
    input  logic                           dec_write,
    output logic [FLD_W-1:0]               dec_idx,
    output logic                           dec_err,
    // access-phase port, driven from the completer's latched transfer
    input  logic [FLD_W-1:0]               acc_idx,
    input  logic                           we,
    input  logic [APB_DATA_W-1:0]          wdata,
    input  logic [3:0]                     strb,
    output logic [APB_DATA_W-1:0]          rdata,
    // hardware side
    input  logic [APB_DATA_W*NUM_REGS-1:0] hw_in,
    output logic [APB_DATA_W*NUM_REGS-1:0] reg_out
);

    logic [APB_DATA_W-1:0] regs [NUM_REGS];

    // Decode one bit above the register field so the address just past the
    // bank reports an error instead of aliasing onto register 0.
    always_comb begin
        dec_idx = dec_addr[FLD_W+1:2];
        dec_err = 1'b0;
        if (dec_addr[1:0] != 2'b00) begin
            dec_err = 1'b1;
        end
        if (int'(dec_idx) >= NUM_REGS) begin
            dec_err = 1'b1;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(dec_idx) == i && dec_write && RO_MASK[i]) begin
                dec_err = 1'b1;
            end
        end
    end

    // Storage with per-lane write merge; read-only slots are never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (int'(acc_idx) == i && !RO_MASK[i]) begin
                    for (int k = 0; k < 4; k++) begin
                        if (strb[k]) begin
                            regs[i][8*k +: 8] <= wdata[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux: RO slots return the live hardware status word.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(acc_idx) == i) begin
                rdata = RO_MASK[i] ? hw_in[APB_DATA_W*i +: APB_DATA_W] : regs[i];
            end
        end
    end

    // Register contents toward hardware; RO slots have no storage to expose.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[APB_DATA_W*i +: APB_DATA_W] = RO_MASK[i] ? '0 : regs[i];
        end
    end

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer: register bank behind a fixed wait-state access phase.
// Transfer parameters and the error verdict are captured at setup; ready is
// decoded from the ACCESS state and writes commit on the completion edge.
// Build macro APB_PSTRB_EN adds the byte-lane strobe input on the bus.
module apb_reg_completer
    import apb_pkg::*;
#(
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    apb_reg_completer_if.slave             bus,
    input  logic [APB_DATA_W*NUM_REGS-1:0] hwIn,
    output logic [APB_DATA_W*NUM_REGS-1:0] regOut,
    output state_t                         dbg_state
);

    localparam int         FLD_W     = apb_idx_w(NUM_REGS) + 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [FLD_W-1:0]      idx_q;
    logic                  wr_q;
    logic                  err_q;
    logic [APB_DATA_W-1:0] wdata_q;
    logic [3:0]            strb_q;

    logic [FLD_W-1:0]      dec_idx;
    logic                  dec_err;
    logic [APB_DATA_W-1:0] bank_rdata;
    logic [3:0]            strb_in;
    logic                  setup;
    logic                  commit;
    logic                  unused_addr;

`ifdef APB_PSTRB_EN
    assign strb_in = bus.strb;
`else
    assign strb_in = 4'hF;
`endif

    // Upper address bits are outside the decoded window.
    assign unused_addr = &{1'b0, bus.addr[APB_DATA_W-1:FLD_W+2]};

    assign setup  = bus.sel & ~bus.enable;
    assign commit = (state == ACCESS) & bus.sel & bus.enable & wr_q & ~err_q;

    // Transfer FSM: capture at setup, count wait states, complete in ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // enable without a preceding setup cycle is not a transfer
                    if (setup) begin
                        idx_q    <= dec_idx;
                        wr_q     <= bus.write;
                        wdata_q  <= bus.wData;
                        strb_q   <= strb_in;
                        err_q    <= dec_err;
                        wait_cnt <= WAIT_LOAD;
                        state    <= (WAIT_STATES == 0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    if (!bus.sel) begin
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else if (bus.enable) begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt <= 4'd1) begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!bus.sel || bus.enable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready  = (state == ACCESS);
    assign bus.slvErr = (bus.ready && err_q) ? RESP_ERR : RESP_OKAY;
    assign bus.rData  = (bus.ready && !wr_q && !err_q) ? bank_rdata : '0;
    assign dbg_state  = state;

    apb_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK),
        .FLD_W    (FLD_W)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .dec_addr  (bus.addr[FLD_W+1:0]),
        .dec_write (bus.write),
        .dec_idx   (dec_idx),
        .dec_err   (dec_err),
        .acc_idx   (idx_q),
        .we        (commit),
        .wdata     (wdata_q),
        .strb      (strb_q),
        .rdata     (bank_rdata),
        .hw_in     (hwIn),
        .reg_out   (regOut)
    );

endmodule

// File: tb/tb_apb_reg_completer.sv
// Bench for apb_reg_completer: two instances share one stimulus stream,
// dut_a (WAIT_STATES=1, register 0 read-only) and dut_b (WAIT_STATES=0, all RW).
// Define APB_PSTRB_EN to include the byte-strobe vectors.
module tb_apb_reg_completer;
    import apb_pkg::*;

    localparam int NR = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- bus stimulus ----------------
    logic        sel, enable, write;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic [32*NR-1:0] hw_in;
    logic [32*NR-1:0] reg_a, reg_b;
    state_t      st_a, st_b;

    apb_reg_completer_if bus_a ();
    apb_reg_completer_if bus_b ();

    assign bus_a.sel = sel;    assign bus_b.sel = sel;
    assign bus_a.enable = enable; assign bus_b.enable = enable;
    assign bus_a.write = write;  assign bus_b.write = write;
    assign bus_a.addr = addr;   assign bus_b.addr = addr;
    assign bus_a.wData = wdata;  assign bus_b.wData = wdata;
`ifdef APB_PSTRB_EN
    assign bus_a.strb = strb;   assign bus_b.strb = strb;
`endif

    apb_reg_completer #(.NUM_REGS(NR), .WAIT_STATES(1), .RO_MASK(8'h01)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .hwIn(hw_in), .regOut(reg_a), .dbg_state(st_a)
    );
    apb_reg_completer #(.NUM_REGS(NR), .WAIT_STATES(0), .RO_MASK(8'h00)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .hwIn(hw_in), .regOut(reg_b), .dbg_state(st_b)
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    // {latency[3:0], slvErr, rData[31:0]}
    logic [36:0] exp_a_q[$];
    logic [36:0] exp_b_q[$];
    logic [36:0] e_a, e_b;
    int cnt_a = 0;
    int cnt_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] slot(input logic [32*NR-1:0] v, input int i);
        return v[32*i +: 32];
    endfunction

    // Monitor A: counts enable cycles and checks each completed transfer.
    always @(negedge clk) begin
        if (reset) begin
            cnt_a = 0;
        end else if (sel && enable) begin
            cnt_a++;
            if (bus_a.ready) begin
                if (exp_a_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL a_unexpected_ready: got ready=1 expected no transfer");
                end else begin
                    e_a = exp_a_q.pop_front();
                    check("a_rdata", bus_a.rData, e_a[31:0]);
                    check("a_slverr", {31'b0, bus_a.slvErr}, {31'b0, e_a[32]});
                    check("a_latency", 32'(cnt_a), {28'b0, e_a[36:33]});
                end
                cnt_a = 0;
            end else begin
                check("a_idle_outputs", {bus_a.slvErr, bus_a.rData[30:0]}, 32'h0);
            end
        end else begin
            cnt_a = 0;
        end
    end

    // Monitor B: same checks for the zero-wait-state instance.
    always @(negedge clk) begin
        if (reset) begin
            cnt_b = 0;
        end else if (sel && enable) begin
            cnt_b++;
            if (bus_b.ready) begin
                if (exp_b_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL b_unexpected_ready: got ready=1 expected no transfer");
                end else begin
                    e_b = exp_b_q.pop_front();
                    check("b_rdata", bus_b.rData, e_b[31:0]);
                    check("b_slverr", {31'b0, bus_b.slvErr}, {31'b0, e_b[32]});
                    check("b_latency", 32'(cnt_b), {28'b0, e_b[36:33]});
                end
                cnt_b = 0;
            end else begin
                check("b_idle_outputs", {bus_b.slvErr, bus_b.rData[30:0]}, 32'h0);
            end
        end else begin
            cnt_b = 0;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 right after the completion edge,
    // so consecutive calls are back-to-back with no idle cycle.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] ra, input logic ea, input logic [31:0] rb, input logic eb);
        bit done;
        sel = 1'b1; enable = 1'b0; addr = a; write = w; wdata = d; strb = s;
        exp_a_q.push_back({4'd2, ea, ra});
        exp_b_q.push_back({4'd1, eb, rb});
        @(posedge clk); #1;
        enable = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (bus_a.ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL xfer_timeout: got no ready expected ready at addr %h", a);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        sel = 1'b0; enable = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        sel = 1'b0; enable = 1'b0; write = 1'b0; addr = '0; wdata = '0; strb = 4'hF;
        hw_in = '0;
        hw_in[31:0] = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        check("a_ready_rst", {31'b0, bus_a.ready}, 32'h0);
        check("b_ready_rst", {31'b0, bus_b.ready}, 32'h0);
        check("a_slverr_rst", {31'b0, bus_a.slvErr}, 32'h0);
        check("a_rdata_rst", bus_a.rData, 32'h0);
        check("b_rdata_rst", bus_b.rData, 32'h0);
        check("a_state_rst", {30'b0, st_a}, {30'b0, IDLE});
        check("b_state_rst", {30'b0, st_b}, {30'b0, IDLE});
        for (int i = 0; i < NR; i++) begin
            check("a_regout_rst", slot(reg_a, i), 32'h0);
            check("b_regout_rst", slot(reg_b, i), 32'h0);
        end

        reset = 1'b0;
        @(posedge clk); #1;

        // enable without a setup cycle must be ignored
        sel = 1'b1; enable = 1'b1; write = 1'b1; addr = 32'h08; wdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(posedge clk); #1;
            check("a_ready_nosetup", {31'b0, bus_a.ready}, 32'h0);
            check("b_ready_nosetup", {31'b0, bus_b.ready}, 32'h0);
        end
        idle(1);
        check("a_slot2_nosetup", slot(reg_a, 2), 32'h0);

        // write then read register 2
        xfer(32'h08, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
        xfer(32'h08, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0);
        check("a_slot2", slot(reg_a, 2), 32'hDEAD_BEEF);
        check("b_slot2", slot(reg_b, 2), 32'hDEAD_BEEF);

        // index 8 is past the bank
        xfer(32'h20, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1);

        // back-to-back write/read of register 1
        xfer(32'h04, 1'b1, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
        xfer(32'h04, 1'b0, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0);

        // misaligned write leaves register 1 untouched
        xfer(32'h06, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1);
        check("a_slot1_misaligned", slot(reg_a, 1), 32'hCAFE_F00D);
        check("b_slot1_misaligned", slot(reg_b, 1), 32'hCAFE_F00D);

        // register 0: read-only hw status on A, plain storage on B
        xfer(32'h00, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
        xfer(32'h00, 1'b1, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b1, 32'h0, 1'b0);
        xfer(32'h00, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 32'h0BAD_F00D, 1'b0);
        check("a_slot0_ro", slot(reg_a, 0), 32'h0);
        check("b_slot0", slot(reg_b, 0), 32'h0BAD_F00D);

        // last register, upper address bits ignored
        xfer(32'hF000_001C, 1'b1, 32'h8765_4321, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
        xfer(32'h1C, 1'b0, 32'h0, 4'hF, 32'h8765_4321, 1'b0, 32'h8765_4321, 1'b0);
        check("a_slot7", slot(reg_a, 7), 32'h8765_4321);

`ifdef APB_PSTRB_EN
        // byte-lane merge and strb=0 no-op
        xfer(32'h10, 1'b1, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
        xfer(32'h10, 1'b1, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 32'h0, 1'b0);
        xfer(32'h10, 1'b1, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0);
        xfer(32'h10, 1'b0, 32'h0, 4'b0000, 32'hAA22_CC44, 1'b0, 32'hAA22_CC44, 1'b0);
        check("a_slot4_strb", slot(reg_a, 4), 32'hAA22_CC44);
`endif

        idle(1);

        // reset during the access phase of a write to register 3
        sel = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h0C; wdata = 32'h7777_7777;
        @(posedge clk); #1;
        enable = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("a_ready_midreset", {31'b0, bus_a.ready}, 32'h0);
        check("b_ready_midreset", {31'b0, bus_b.ready}, 32'h0);
        check("a_state_midreset", {30'b0, st_a}, {30'b0, IDLE});
        sel = 1'b0; enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("a_slot3_after_reset", slot(reg_a, 3), 32'h0);
        check("b_slot3_after_reset", slot(reg_b, 3), 32'h0);
        check("a_slot2_after_reset", slot(reg_a, 2), 32'h0);
        xfer(32'h0C, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);

        idle(3);
        check("a_queue_drained", 32'(exp_a_q.size()), 32'h0);
        check("b_queue_drained", 32'(exp_b_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time bound in case the sequence stalls somewhere unexpected.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish before %0t", $time);
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

endmodule
